// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one radix-2 shift-add / restoring shift-subtract step per cycle.
// Optional MD_EARLY_OUT_EN: divide-by-zero, signed-overflow and x0 multiplies skip the iteration.
module muldiv_unit #(
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [2:0]        i_md_op,
  input  logic [DATA_W-1:0] i_op_a,
  input  logic [DATA_W-1:0] i_op_b,
  input  logic              i_flush,
  output logic              o_busy,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_result,
  output logic [1:0]        o_dbg_state
);

  typedef enum logic [1:0] {IDLE, CALC, FIN, DONE} state_t;

  localparam int AW = 2*DATA_W + 1;
  localparam int CW = $clog2(DATA_W);
  localparam logic [DATA_W-1:0] MIN  = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] ONES = {DATA_W{1'b1}};
  localparam logic [CW-1:0]     LAST = CW'(DATA_W-1);

  state_t state, state_nxt;

  logic [AW-1:0]     acc;
  logic [DATA_W-1:0] mag_b;
  logic [2:0]        op_q;
  logic              neg_q;
  logic              special_q;
  logic [DATA_W-1:0] special_val_q;
  logic [CW-1:0]     cnt;

  // Handshake: a request is taken on a rising edge with i_start=1, i_flush=0 and o_busy=0;
  // the result is returned by a single-cycle o_valid pulse and holds until the next accept.
  logic accept;
  assign accept = (state == IDLE) && i_start && !i_flush;

  // Operand decode at accept
  logic              is_div, sgn_a_op, sgn_b_op, sa, sb, div0, ovf, special_in, early;
  logic [DATA_W-1:0] mag_a_in, mag_b_in, special_val_in;

  always_comb begin
    is_div   = i_md_op[2];
    sgn_a_op = (i_md_op == 3'd1) || (i_md_op == 3'd2) || (i_md_op == 3'd4) || (i_md_op == 3'd6);
    sgn_b_op = (i_md_op == 3'd1) || (i_md_op == 3'd4) || (i_md_op == 3'd6);
    sa       = sgn_a_op && i_op_a[DATA_W-1];
    sb       = sgn_b_op && i_op_b[DATA_W-1];
    mag_a_in = sa ? (~i_op_a + 1'b1) : i_op_a;
    mag_b_in = sb ? (~i_op_b + 1'b1) : i_op_b;
    div0     = is_div && (i_op_b == '0);
    ovf      = ((i_md_op == 3'd4) || (i_md_op == 3'd6)) && (i_op_a == MIN) && (i_op_b == ONES);
    special_in     = div0 || ovf || (!is_div && (i_op_b == '0));
    special_val_in = '0;
    if (div0)     special_val_in = i_md_op[1] ? i_op_a : ONES;
    else if (ovf) special_val_in = i_md_op[1] ? '0 : MIN;
  end

`ifdef MD_EARLY_OUT_EN
  assign early = special_in;
`else
  assign early = 1'b0;
`endif

  // One iteration step of each algorithm
  logic [DATA_W:0]   mul_sum;
  logic [DATA_W+1:0] div_diff;
  logic [AW-1:0]     acc_step;

  always_comb begin
    mul_sum  = acc[AW-1:DATA_W] + (acc[0] ? {1'b0, mag_b} : '0);
    div_diff = {1'b0, acc[2*DATA_W-1:DATA_W-1]} - {2'b00, mag_b};
    if (!op_q[2])
      acc_step = {1'b0, mul_sum, acc[DATA_W-1:1]};
    else if (div_diff[DATA_W+1])
      acc_step = {acc[2*DATA_W-1:0], 1'b0};
    else
      acc_step = {div_diff[DATA_W:0], acc[DATA_W-2:0], 1'b1};
  end

  // Sign correction and result select
  logic [2*DATA_W-1:0] prod_s;
  logic [DATA_W-1:0]   quot_s, rem_s, sel_result;

  always_comb begin
    prod_s = neg_q ? (~acc[2*DATA_W-1:0] + 1'b1) : acc[2*DATA_W-1:0];
    quot_s = neg_q ? (~acc[DATA_W-1:0] + 1'b1) : acc[DATA_W-1:0];
    rem_s  = neg_q ? (~acc[2*DATA_W-1:DATA_W] + 1'b1) : acc[2*DATA_W-1:DATA_W];
    case (op_q)
      3'd0:          sel_result = prod_s[DATA_W-1:0];
      3'd1, 3'd2,
      3'd3:          sel_result = prod_s[2*DATA_W-1:DATA_W];
      3'd4, 3'd5:    sel_result = quot_s;
      default:       sel_result = rem_s;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = early ? FIN : CALC;
      CALC: if (i_flush) state_nxt = IDLE;
            else if (cnt == LAST) state_nxt = FIN;
      FIN:  state_nxt = i_flush ? IDLE : DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc           <= '0;
      mag_b         <= '0;
      op_q          <= '0;
      neg_q         <= 1'b0;
      special_q     <= 1'b0;
      special_val_q <= '0;
      cnt           <= '0;
      o_result      <= '0;
    end else begin
      if (accept) begin
        acc           <= {{(DATA_W+1){1'b0}}, mag_a_in};
        mag_b         <= mag_b_in;
        op_q          <= i_md_op;
        // Remainder takes the dividend's sign; everything else the product of signs
        neg_q         <= (is_div && i_md_op[1]) ? sa : (sa ^ sb);
        special_q     <= special_in;
        special_val_q <= special_val_in;
        cnt           <= '0;
      end else if (state == CALC && !i_flush) begin
        acc <= acc_step;
        cnt <= cnt + 1'b1;
      end
      if (state == FIN && !i_flush)
        o_result <= special_q ? special_val_q : sel_result;
    end
  end

  assign o_busy      = (state != IDLE);
  assign o_valid     = (state == DONE);
  assign o_dbg_state = state;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases, flush/reset scenarios and
// randomized operations compared with an arithmetic reference model.
module tb_muldiv_unit;

  localparam int W = 32;
  localparam logic [W-1:0] MIN  = 32'h8000_0000;
  localparam logic [W-1:0] ONES = 32'hFFFF_FFFF;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   md_op = '0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         flush = 1'b0;
  logic         busy, valid;
  logic [W-1:0] result;
  logic [1:0]   dbg_state;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  muldiv_unit #(.DATA_W(W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_md_op(md_op),
    .i_op_a(op_a), .i_op_b(op_b), .i_flush(flush),
    .o_busy(busy), .o_valid(valid), .o_result(result), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference model: RV32M semantics in plain 64-bit arithmetic
  function automatic logic [W-1:0] ref_md(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'b0, a});
    longint ub = longint'({32'b0, b});
    logic [63:0] p;
    logic [W-1:0] r;
    r = '0;
    case (op)
      3'd0: begin p = 64'(ua * ub); r = p[31:0];  end
      3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
      3'd2: begin p = 64'(sa * ub); r = p[63:32]; end
      3'd3: begin p = 64'(ua * ub); r = p[63:32]; end
      3'd4: if (b == 0) r = ONES; else if (a == MIN && b == ONES) r = MIN; else r = 32'(sa / sb);
      3'd5: r = (b == 0) ? ONES : a / b;
      3'd6: if (b == 0) r = a; else if (a == MIN && b == ONES) r = '0; else r = 32'(sa % sb);
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int exp_latency(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bit special;
    special = (b == 0) || ((op == 3'd4 || op == 3'd6) && a == MIN && b == ONES);
`ifdef MD_EARLY_OUT_EN
    return special ? 1 : 33;
`else
    return special ? 33 : 33;
`endif
  endfunction

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return MIN;
      2: return ONES;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!valid && lat < 100);
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] expv);
    int lat;
    logic [W-1:0] e;
    exp_q.push_back(expv);
    @(negedge clk);
    start = 1'b1; md_op = op; op_a = a; op_b = b;
    @(posedge clk); #1;
    start = 1'b0; op_a = $urandom; op_b = $urandom; md_op = 3'($urandom_range(0, 7));
    check({tag, "_busy"}, W'(busy), W'(1));
    wait_valid(lat);
    check({tag, "_latency"}, W'(lat), W'(exp_latency(op, a, b)));
    e = exp_q.pop_front();
    check({tag, "_result"}, result, e);
    @(posedge clk); #1;
    check({tag, "_valid_pulse"}, W'(valid), W'(0));
    check({tag, "_busy_done"}, W'(busy), W'(0));
    check({tag, "_result_hold"}, result, e);
  endtask

  initial begin
    int lat;
    logic [W-1:0] prev;
    logic [2:0] rop;
    logic [W-1:0] ra, rb;
    bit saw_valid;

    // Reset state
    #12;
    check("reset_busy", W'(busy), W'(0));
    check("reset_valid", W'(valid), W'(0));
    check("reset_result", result, '0);
    @(negedge clk); rst_n = 1'b1;

    // Directed cases
    run_op("mul_7_m3",     3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run_op("mulh_min_min", 3'd1, MIN,          MIN,           32'h4000_0000);
    run_op("mulhu_ones",   3'd3, ONES,         ONES,          32'hFFFF_FFFE);
    run_op("mulhsu_m1_2",  3'd2, ONES,         32'd2,         32'hFFFF_FFFF);
    run_op("div_m7_2",     3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD);
    run_op("rem_m7_2",     3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF);
    run_op("divu_100_7",   3'd5, 32'd100,      32'd7,         32'd14);
    run_op("remu_100_7",   3'd7, 32'd100,      32'd7,         32'd2);
    run_op("divu_by0",     3'd5, 32'd5,        32'd0,         ONES);
    run_op("remu_by0",     3'd7, 32'd5,        32'd0,         32'd5);
    run_op("div_ovf",      3'd4, MIN,          ONES,          MIN);
    run_op("rem_ovf",      3'd6, MIN,          ONES,          32'd0);
    run_op("mul_by0",      3'd0, 32'd1234,     32'd0,         32'd0);

    // Flush on the 10th edge after accept
    prev = result;
    @(negedge clk);
    start = 1'b1; md_op = 3'd4; op_a = 32'd1000; op_b = 32'd3;
    @(posedge clk); #1; start = 1'b0;
    saw_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; if (valid) saw_valid = 1'b1; end
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", W'(busy), W'(0));
    check("flush_valid", W'(valid), W'(0));
    check("flush_result_kept", result, prev);
    repeat (40) begin @(posedge clk); #1; if (valid) saw_valid = 1'b1; end
    check("flush_no_valid", W'(saw_valid), W'(0));
    run_op("mul_after_flush", 3'd0, 32'd3, 32'd4, 32'd12);

    // Start together with flush in IDLE is rejected
    @(negedge clk);
    start = 1'b1; flush = 1'b1; md_op = 3'd0; op_a = 32'd5; op_b = 32'd6;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("start_flush_rejected", W'(busy), W'(0));

    // Asynchronous reset mid-CALC
    @(negedge clk);
    start = 1'b1; md_op = 3'd5; op_a = 32'd999; op_b = 32'd7;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", W'(busy), W'(0));
    check("async_rst_valid", W'(valid), W'(0));
    check("async_rst_result", result, '0);
    @(negedge clk); rst_n = 1'b1;

    // i_start held through busy with changing operands: only the first request counts
    @(negedge clk);
    start = 1'b1; md_op = 3'd0; op_a = 32'd11; op_b = 32'd13;
    @(posedge clk); #1;
    md_op = 3'd3; op_a = 32'hDEAD_BEEF; op_b = 32'h1234_5678;
    wait_valid(lat);
    check("held_start_latency", W'(lat), W'(33));
    check("held_start_result", result, 32'd143);
    @(negedge clk); start = 1'b0;
    @(posedge clk); #1;
    check("held_start_idle", W'(busy), W'(0));

    // Randomized operations against the reference model
    for (int i = 0; i < 24; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra = pick_operand();
      rb = pick_operand();
      run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, ref_md(rop, ra, rb));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
